// File: rtl/rs232_cmd_ctrl_if.sv
// Byte-stream, memory and transmitter handshake bundle for the RS232 command controller.
// master = controller side, slave = receiver/memory/transmitter side.
interface rs232_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perr;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    modport master (
        input  rx_data, rx_valid, rx_perr, mem_rdata, tx_busy,
        output mem_addr, mem_wdata, mem_we, mem_re, tx_data, tx_start
    );

    modport slave (
        output rx_data, rx_valid, rx_perr, mem_rdata, tx_busy,
        input  mem_addr, mem_wdata, mem_we, mem_re, tx_data, tx_start
    );
endinterface

// File: rtl/rs232_cmd_ctrl.sv
// RS232 command decoder: WRITE / READ / ERASE / PROT commands from received bytes,
// driving a byte-wide memory and the transmitter, with write protection and inter-byte timeout.
module rs232_cmd_ctrl #(
    parameter int unsigned RS232_RATIO   = 1736,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    rs232_cmd_ctrl_if.master bus,
    output logic             end_of_erase,
    output logic             prot,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             busy
);
    localparam logic [25:0] TMO_LIMIT = 26'(RS232_RATIO * 11 * TIMEOUT_BYTES);

    localparam logic [7:0] OP_WRITE  = 8'hC0;
    localparam logic [7:0] OP_READ   = 8'h80;
    localparam logic [7:0] OP_ERASE  = 8'h40;
    localparam logic [7:0] OP_PROT   = 8'h05;
    localparam logic [7:0] ERASE_KEY_VAL = 8'h5A;

    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_PROT   = 2'b10;
    localparam logic [1:0] ERR_OPCODE = 2'b11;

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, TX_REQ,
        ERASE_KEY, ERASE_FILL, ERASE_RUN, PROT_K1, PROT_K2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  addr_q, data_q, tx_q;
    logic        is_rd;
    logic [25:0] tmo_cnt;
    logic        waiting, tmo_hit;

    logic       err_set, tx_start_set, eoe_set;
    logic [1:0] err_code_set;
    logic       rd_ld, rd_val, addr_ld, addr_clr, addr_inc, data_ld, tx_ld;
    logic       prot_set, prot_clr;

    assign waiting = state inside {GET_ADDR, GET_DATA, ERASE_KEY, ERASE_FILL, PROT_K1, PROT_K2};
    assign tmo_hit = (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        err_set      = 1'b0;
        err_code_set = 2'b00;
        tx_start_set = 1'b0;
        eoe_set      = 1'b0;
        rd_ld        = 1'b0;
        rd_val       = 1'b0;
        addr_ld      = 1'b0;
        addr_clr     = 1'b0;
        addr_inc     = 1'b0;
        data_ld      = 1'b0;
        tx_ld        = 1'b0;
        prot_set     = 1'b0;
        prot_clr     = 1'b0;

        // A parity error in any byte-receiving state aborts whatever was collected so far.
        if ((waiting || state == IDLE) && bus.rx_valid && bus.rx_perr) begin
            err_set      = 1'b1;
            err_code_set = ERR_PARITY;
            state_nxt    = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.rx_valid) begin
                    case (bus.rx_data)
                        OP_WRITE: begin state_nxt = GET_ADDR; rd_ld = 1'b1; rd_val = 1'b0; end
                        OP_READ:  begin state_nxt = GET_ADDR; rd_ld = 1'b1; rd_val = 1'b1; end
                        OP_ERASE: state_nxt = ERASE_KEY;
                        OP_PROT:  state_nxt = PROT_K1;
                        default: begin err_set = 1'b1; err_code_set = ERR_OPCODE; end
                    endcase
                end
                GET_ADDR: if (bus.rx_valid) begin
                    addr_ld   = 1'b1;
                    state_nxt = is_rd ? MEM_RD : GET_DATA;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
                GET_DATA: if (bus.rx_valid) begin
                    if (prot) begin
                        err_set = 1'b1; err_code_set = ERR_PROT; state_nxt = IDLE;
                    end else begin
                        data_ld = 1'b1; state_nxt = MEM_WR;
                    end
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
                MEM_WR:  state_nxt = IDLE;
                MEM_RD:  state_nxt = RD_WAIT;
                RD_WAIT: begin tx_ld = 1'b1; state_nxt = TX_REQ; end
                TX_REQ: if (!bus.tx_busy) begin
                    tx_start_set = 1'b1; state_nxt = IDLE;
                end
                ERASE_KEY: if (bus.rx_valid) begin
                    if (bus.rx_data == ERASE_KEY_VAL) state_nxt = ERASE_FILL;
                    else begin err_set = 1'b1; err_code_set = ERR_OPCODE; state_nxt = IDLE; end
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
                ERASE_FILL: if (bus.rx_valid) begin
                    if (prot) begin
                        err_set = 1'b1; err_code_set = ERR_PROT; state_nxt = IDLE;
                    end else begin
                        data_ld = 1'b1; addr_clr = 1'b1; state_nxt = ERASE_RUN;
                    end
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
                ERASE_RUN: begin
                    addr_inc = 1'b1;
                    if (addr_q == 8'hFF) begin eoe_set = 1'b1; state_nxt = IDLE; end
                end
                PROT_K1: if (bus.rx_valid) begin
                    data_ld = 1'b1; state_nxt = PROT_K2;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
                PROT_K2: if (bus.rx_valid) begin
                    state_nxt = IDLE;
                    if (data_q == 8'h34 && bus.rx_data == 8'h78)      prot_clr = 1'b1;
                    else if (data_q == 8'h12 && bus.rx_data == 8'h56) prot_set = 1'b1;
                    else begin err_set = 1'b1; err_code_set = ERR_OPCODE; end
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Timeout runs only while waiting for a command byte; any received byte restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          tmo_cnt <= '0;
        else if (!waiting || bus.rx_valid) tmo_cnt <= '0;
        else                               tmo_cnt <= tmo_cnt + 26'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            data_q       <= '0;
            tx_q         <= '0;
            is_rd        <= 1'b0;
            prot         <= 1'b1;
            err          <= 1'b0;
            err_code     <= 2'b00;
            end_of_erase <= 1'b0;
            bus.tx_start <= 1'b0;
        end else begin
            err          <= err_set;
            end_of_erase <= eoe_set;
            bus.tx_start <= tx_start_set;
            if (err_set)  err_code <= err_code_set;
            if (rd_ld)    is_rd    <= rd_val;
            if (data_ld)  data_q   <= bus.rx_data;
            if (tx_ld)    tx_q     <= bus.mem_rdata;
            if (prot_set) prot     <= 1'b1;
            if (prot_clr) prot     <= 1'b0;
            if (addr_clr)      addr_q <= '0;
            else if (addr_ld)  addr_q <= bus.rx_data;
            else if (addr_inc) addr_q <= addr_q + 8'd1;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q;
    assign bus.tx_data   = tx_q;
    assign bus.mem_we    = (state == MEM_WR) || (state == ERASE_RUN);
    assign bus.mem_re    = (state == MEM_RD);
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_rs232_cmd_ctrl.sv
// Randomised command-level bench for rs232_cmd_ctrl: a byte-level command interpreter
// predicts writes, transmitted bytes, errors and erase completions, compared per command.
module tb_rs232_cmd_ctrl;
    localparam int unsigned RATIO  = 16;
    localparam int unsigned TBYTES = 4;
    localparam int unsigned TMO    = RATIO * 11 * TBYTES;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       end_of_erase, prot, err, busy;
    logic [1:0] err_code;

    rs232_cmd_ctrl_if bus();

    rs232_cmd_ctrl #(.RS232_RATIO(RATIO), .TIMEOUT_BYTES(TBYTES)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .end_of_erase(end_of_erase), .prot(prot), .err(err),
        .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  env_mem [256];
    logic [7:0]  ref_mem [256];
    logic        m_prot = 1'b1;
    logic [7:0]  cmd_q [$];

    logic [15:0] obs_wr [$];
    int unsigned obs_wr_cyc [$];
    logic [7:0]  obs_tx [$];
    logic [1:0]  obs_err [$];
    int          obs_eoe = 0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_tx [$];
    logic [1:0]  exp_err [$];
    int          exp_eoe = 0;
    int          wr_ptr = 0, tx_ptr = 0, err_ptr = 0, eoe_ptr = 0;

    int unsigned cyc = 0;
    int unsigned busy_until = 0;
    int unsigned fall_cyc = 0;
    int unsigned last_we_cyc = 0;
    bit          lat_check = 1'b0;
    logic        prev_re = 1'b0;
    logic [7:0]  prev_addr = 8'h00;
    logic        nb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Environment: records DUT activity, models memory read latency and transmitter busy.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (bus.mem_we || bus.mem_re)
                check("we_re_exclusive", 32'(bus.mem_we & bus.mem_re), 32'd0);
            if (bus.mem_we) begin
                obs_wr.push_back({bus.mem_addr, bus.mem_wdata});
                obs_wr_cyc.push_back(cyc);
                env_mem[bus.mem_addr] = bus.mem_wdata;
                last_we_cyc = cyc;
            end
            if (bus.tx_start) begin
                obs_tx.push_back(bus.tx_data);
                check("tx_while_busy", 32'(bus.tx_busy), 32'd0);
                if (lat_check) check("tx_latency", cyc, fall_cyc + 1);
            end
            if (err) obs_err.push_back(err_code);
            if (end_of_erase) begin
                obs_eoe++;
                check("eoe_latency", cyc - last_we_cyc, 32'd1);
            end
        end
        bus.mem_rdata = prev_re ? env_mem[prev_addr] : 8'($urandom);
        prev_re   = bus.mem_re;
        prev_addr = bus.mem_addr;
        nb = (cyc < busy_until);
        if (bus.tx_busy === 1'b1 && !nb) fall_cyc = cyc;
        bus.tx_busy = nb;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe);
        bus.rx_data  = b;
        bus.rx_perr  = pe;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
        bus.rx_perr  = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 3)) step();
    endtask

    task automatic model_cmd(input int perr_at);
        int n;
        n = cmd_q.size();
        if (perr_at >= 0) begin
            exp_err.push_back(2'b01);
            return;
        end
        case (cmd_q[0])
            8'hC0: if (n == 3) begin
                if (m_prot) exp_err.push_back(2'b10);
                else begin
                    exp_wr.push_back({cmd_q[1], cmd_q[2]});
                    ref_mem[cmd_q[1]] = cmd_q[2];
                end
            end
            8'h80: if (n == 2) exp_tx.push_back(ref_mem[cmd_q[1]]);
            8'h40: begin
                if (cmd_q[1] != 8'h5A) exp_err.push_back(2'b11);
                else if (m_prot)       exp_err.push_back(2'b10);
                else begin
                    for (int a = 0; a < 256; a++) begin
                        exp_wr.push_back({8'(a), cmd_q[2]});
                        ref_mem[a] = cmd_q[2];
                    end
                    exp_eoe++;
                end
            end
            8'h05: begin
                if (cmd_q[1] == 8'h34 && cmd_q[2] == 8'h78)      m_prot = 1'b0;
                else if (cmd_q[1] == 8'h12 && cmd_q[2] == 8'h56) m_prot = 1'b1;
                else exp_err.push_back(2'b11);
            end
            default: exp_err.push_back(2'b11);
        endcase
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < limit) begin
            step();
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        repeat (3) step();
    endtask

    task automatic compare_cmd();
        int n_wr, n_tx, n_er;
        n_wr = obs_wr.size() - wr_ptr;
        n_tx = obs_tx.size() - tx_ptr;
        n_er = obs_err.size() - err_ptr;
        check("wr_count", 32'(n_wr), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < n_wr; i++)
            check("wr_addr_data", 32'(obs_wr[wr_ptr + i]), 32'(exp_wr[i]));
        if (exp_wr.size() == 256 && n_wr == 256)
            check("erase_contiguous", obs_wr_cyc[wr_ptr + 255] - obs_wr_cyc[wr_ptr], 32'd255);
        check("tx_count", 32'(n_tx), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < n_tx; i++)
            check("tx_data", 32'(obs_tx[tx_ptr + i]), 32'(exp_tx[i]));
        check("err_count", 32'(n_er), 32'(exp_err.size()));
        for (int i = 0; i < exp_err.size() && i < n_er; i++)
            check("err_code", 32'(obs_err[err_ptr + i]), 32'(exp_err[i]));
        check("eoe_count", 32'(obs_eoe - eoe_ptr), 32'(exp_eoe));
        check("prot", 32'(prot), 32'(m_prot));
        wr_ptr  = obs_wr.size();
        tx_ptr  = obs_tx.size();
        err_ptr = obs_err.size();
        eoe_ptr = obs_eoe;
        exp_wr.delete();
        exp_tx.delete();
        exp_err.delete();
        exp_eoe = 0;
    endtask

    task automatic run_cmd(input int perr_at, input int busy_n, input bit noise);
        model_cmd(perr_at);
        busy_until = cyc + 32'(busy_n);
        for (int i = 0; i < cmd_q.size(); i++) begin
            send_byte(cmd_q[i], 1'(i == perr_at));
            if (i == perr_at) break;
        end
        if (noise) begin
            repeat (10) step();
            send_byte(8'hC0, 1'b0);
            send_byte(8'h33, 1'b1);
            send_byte(8'h05, 1'b0);
        end
        wait_idle(3000);
        compare_cmd();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int kind, pe, bz;
        logic [7:0] a, d, k;
        logic [7:0] fill;
        int n;

        bus.rx_valid = 1'b0;
        bus.rx_perr  = 1'b0;
        bus.rx_data  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end

        repeat (3) step();
        check("rst_prot",      32'(prot), 32'd1);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_mem_re",    32'(bus.mem_re), 32'd0);
        check("rst_tx_start",  32'(bus.tx_start), 32'd0);
        check("rst_eoe",       32'(end_of_erase), 32'd0);
        check("rst_err",       32'(err), 32'd0);
        check("rst_err_code",  32'(err_code), 32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_tx_data",   32'(bus.tx_data), 32'd0);
        rst = 1'b1;
        repeat (2) step();

        cmd_q = {8'hC0, 8'hF1, 8'h8A}; run_cmd(-1, 0, 1'b0);
        cmd_q = {8'h05, 8'h34, 8'h78}; run_cmd(-1, 0, 1'b0);
        cmd_q = {8'hC0, 8'h10, 8'h8A}; run_cmd(-1, 0, 1'b0);

        lat_check = 1'b1;
        cmd_q = {8'h80, 8'h10}; run_cmd(-1, 50, 1'b0);
        lat_check = 1'b0;

        cmd_q = {8'h40, 8'h5A, 8'hAF}; run_cmd(-1, 0, 1'b1);

        cmd_q = {8'h05, 8'h12, 8'h56}; run_cmd(-1, 0, 1'b0);
        cmd_q = {8'h0F};               run_cmd(0, 0, 1'b0);

        send_byte(8'hC0, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (TMO / 2) step();
        check("tmo_still_waiting", 32'(busy), 32'd1);
        repeat (TMO) step();
        check("tmo_dropped", 32'(busy), 32'd0);
        compare_cmd();
        cmd_q = {8'h80, 8'h22}; run_cmd(-1, 0, 1'b0);

        for (int c = 0; c < 40; c++) begin
            kind = $urandom_range(0, 9);
            pe   = -1;
            bz   = 0;
            a    = 8'($urandom);
            d    = 8'($urandom);
            case (kind)
                0, 1, 2: cmd_q = {8'hC0, a, d};
                3, 4: begin cmd_q = {8'h80, a}; bz = $urandom_range(0, 20); end
                5: begin
                    if ($urandom_range(0, 3) != 0) cmd_q = {8'h40, 8'h5A, d};
                    else begin
                        k = 8'($urandom);
                        while (k == 8'h5A) k = 8'($urandom);
                        cmd_q = {8'h40, k};
                    end
                end
                6, 7: begin
                    case ($urandom_range(0, 2))
                        0: cmd_q = {8'h05, 8'h34, 8'h78};
                        1: cmd_q = {8'h05, 8'h12, 8'h56};
                        default: cmd_q = {8'h05, a, d};
                    endcase
                end
                8: begin
                    k = 8'($urandom);
                    while (k == 8'hC0 || k == 8'h80 || k == 8'h40 || k == 8'h05) k = 8'($urandom);
                    cmd_q = {k};
                end
                default: begin cmd_q = {8'hC0, a, d}; pe = $urandom_range(0, 2); end
            endcase
            run_cmd(pe, bz, 1'b0);
        end

        cmd_q = {8'h05, 8'h34, 8'h78}; run_cmd(-1, 0, 1'b0);
        fill = 8'($urandom);
        send_byte(8'h40, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(fill, 1'b0);
        repeat (20) step();
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_erase_we",   32'(bus.mem_we), 32'd0);
        check("rst_mid_erase_busy", 32'(busy), 32'd0);
        check("rst_mid_erase_prot", 32'(prot), 32'd1);
        check("rst_mid_erase_addr", 32'(bus.mem_addr), 32'd0);
        step();
        n = obs_wr.size() - wr_ptr;
        check("partial_erase_started", 32'(n > 0), 32'd1);
        for (int i = 0; i < n; i++)
            check("partial_erase", 32'(obs_wr[wr_ptr + i]), 32'({8'(i), fill}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rs232_cmd_ctrl.md
RS232_CMD_CTRL -- requirements
Module: rs232_cmd_ctrl

Interface
REQ-001 SHALL have parameter: RS232_RATIO, 1736, clock cycles per RS232 bit.
REQ-002 SHALL have parameter: TIMEOUT_BYTES, 4, inter-byte timeout expressed in 11-bit frames.
REQ-003 Port: clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 Port: rst, input, 1, asynchronous, active-low reset.
REQ-005 Port: rx_data, input, 8, byte from the RS232 receiver.
REQ-006 Port: rx_valid, input, 1, one-cycle strobe; rx_data and rx_perr are valid.
REQ-007 Port: rx_perr, input, 1, parity error on the current byte.
REQ-008 Port: mem_addr, output, 8, memory address.
REQ-009 Port: mem_wdata, output, 8, memory write data.
REQ-010 Port: mem_we, output, 1, memory write strobe, one write per cycle high.
REQ-011 Port: mem_re, output, 1, memory read strobe.
REQ-012 Port: mem_rdata, input, 8, read data, valid exactly 1 cycle after mem_re.
REQ-013 Port: tx_data, output, 8, byte to the RS232 transmitter.
REQ-014 Port: tx_start, output, 1, one-cycle transmit request.
REQ-015 Port: tx_busy, input, 1, transmitter is occupied.
REQ-016 Port: end_of_erase, output, 1, one-cycle pulse when an erase completes.
REQ-017 Port: prot, output, 1, write protection active.
REQ-018 Port: err, output, 1, one-cycle error pulse.
REQ-019 Port: err_code, output, 2, error type: 01 parity, 10 protected, 11 bad opcode; holds its value until the next err.
REQ-020 Port: busy, output, 1, high in any state other than IDLE.

Function
REQ-021 SHALL decode the first byte of each command: 0xC0 WRITE, 0x80 READ, 0x40 ERASE, 0x05 PROT; any other value gives err_code 11 and the FSM stays in IDLE.
REQ-022 SHALL implement these FSM states: IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, TX_REQ, ERASE_KEY, ERASE_FILL, ERASE_RUN, PROT_K1, PROT_K2.
REQ-023 WRITE sequence: IDLE -> GET_ADDR -> GET_DATA -> MEM_WR.
  - MEM_WR asserts mem_we for 1 cycle with the latched address and data, then returns to IDLE.
  - If prot=1: no mem_we, err_code 10, return to IDLE after the data byte.
REQ-024 READ sequence: IDLE -> GET_ADDR -> MEM_RD -> RD_WAIT -> TX_REQ.
  - MEM_RD asserts mem_re for 1 cycle.
  - RD_WAIT latches mem_rdata into tx_data.
  - TX_REQ waits while tx_busy=1, then pulses tx_start for 1 cycle and returns to IDLE.
  - READ is allowed regardless of prot.
REQ-025 ERASE sequence: IDLE -> ERASE_KEY; the key byte must be 0x5A, else err_code 11 and return to IDLE.
  - ERASE_FILL latches the fill byte.
  - If prot=1: err_code 10 and return to IDLE.
  - Otherwise ERASE_RUN writes the fill byte to addresses 0x00..0xFF, one per cycle (256 consecutive mem_we cycles).
  - end_of_erase pulses the cycle after the write to 0xFF; the FSM then returns to IDLE.
REQ-026 PROT sequence: IDLE -> PROT_K1 -> PROT_K2.
  - 0x34 then 0x78 clears prot.
  - 0x12 then 0x56 sets prot.
  - Any other pair gives err_code 11 and leaves prot unchanged.
REQ-027 rx_valid with rx_perr=1 in any receiving state SHALL abort the command: err_code 01, return to IDLE, no memory access.
REQ-028 SHALL keep a 26-bit timeout counter, cleared on each accepted byte, running in GET_*, ERASE_KEY, ERASE_FILL and PROT_K* states.
  - On reaching RS232_RATIO*11*TIMEOUT_BYTES, the FSM returns to IDLE silently (no err).
REQ-029 rx_valid in MEM_WR, MEM_RD, RD_WAIT, TX_REQ and ERASE_RUN SHALL be discarded without error.
REQ-030 mem_we and mem_re SHALL never be high in the same cycle.
REQ-031 The ERASE_RUN address counter SHALL be 8 bits; its wrap from 0xFF to 0x00 terminates the erase.

Reset
REQ-032 While rst=0, the following SHALL hold: FSM in IDLE, prot=1, mem_addr=0, mem_wdata=0, tx_data=0, err_code=00, and mem_we, mem_re, tx_start, end_of_erase, err, busy all 0.
REQ-033 Reset asserted mid-erase or mid-command SHALL stop memory strobes immediately and discard partial command state.

Verification
REQ-034 Case 1: after reset, send C0,F1,8A -> no mem_we; err with err_code=10.
REQ-035 Case 2: send 05,34,78 then C0,10,8A -> prot=0; one mem_we with addr 0x10, data 0x8A.
REQ-036 Case 3: send 80,10 with mem_rdata=0x8A and tx_busy high for 50 cycles -> mem_re pulse; tx_start 1 cycle after tx_busy falls; tx_data=0x8A.
REQ-037 Case 4: with prot=0, send 40,5A,AF -> 256 mem_we cycles over addresses 00..FF with data AF; end_of_erase 1 cycle later; bytes sent during the erase are ignored.
REQ-038 Case 5: send 05,12,56, then 0F with a parity error -> prot=1; err with err_code=01; FSM back in IDLE.
REQ-039 Case 6: send C0,22, then stay idle for more than RS232_RATIO*44 cycles, then send 80,22 -> the first command is silently dropped and the read proceeds normally.
